// File: rtl/add_const_arbiter.sv
// add_const_arbiter: round-robin sharing of one add-constant datapath among four requesters,
// with a registered valid/ready result port and a completed-handshake counter.
module add_const_arbiter #(
    parameter int WIDTH  = 4,
    parameter int ADDEND = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [3:0]         i_req,
    input  logic [4*WIDTH-1:0] i_req_data,
    output logic [3:0]         o_gnt,
    output logic               o_busy,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [WIDTH-1:0]   o_out_data,
    output logic [1:0]         o_out_id,
    output logic [7:0]         o_done_cnt
);
    localparam logic [WIDTH-1:0] ADD_W = WIDTH'(ADDEND);
    typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;
    state_t           r_state;
    logic [3:0]       r_gnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_opnd;
    logic [1:0]       r_out_id;
    logic [1:0]       r_id;
    logic [1:0]       r_last;
    logic [7:0]       r_done_cnt;
    logic [1:0]       w_sel;
    // Walk from lowest to highest priority so the nearest requester after r_last wins.
    always_comb begin
        w_sel = r_last;
        for (int k = 4; k >= 1; k--)
            if (i_req[r_last + 2'(k)]) w_sel = r_last + 2'(k);
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_done_cnt  <= '0;
            r_last      <= 2'd3;
            r_opnd      <= '0;
            r_id        <= '0;
        end else begin
            case (r_state)
                IDLE: if (|i_req) begin
                    r_opnd  <= i_req_data[w_sel*WIDTH +: WIDTH];
                    r_id    <= w_sel;
                    r_gnt   <= 4'b0001 << w_sel;
                    r_state <= COMPUTE;
                end
                COMPUTE: begin
                    r_out_data  <= r_opnd + ADD_W;
                    r_out_id    <= r_id;
                    r_out_valid <= 1'b1;
                    r_last      <= r_id;
                    r_gnt       <= '0;
                    r_state     <= HOLD;
                end
                HOLD: if (r_out_valid && i_out_ready) begin
                    r_out_valid <= 1'b0;
                    r_done_cnt  <= r_done_cnt + 8'd1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign o_gnt       = r_gnt;
    assign o_busy      = (r_state != IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_id    = r_out_id;
    assign o_done_cnt  = r_done_cnt;
endmodule

// File: tb/tb_add_const_arbiter.sv
// tb_add_const_arbiter: randomized scenario tasks checked against a round-robin reference model.
module tb_add_const_arbiter;
    localparam int W = 4;
    localparam int ADD = 3;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req = 4'hF;
    logic [4*W-1:0]   req_data = '0;
    logic             out_ready = 1'b0;
    logic [3:0]       gnt;
    logic             busy, out_valid;
    logic [W-1:0]     out_data;
    logic [1:0]       out_id;
    logic [7:0]       done_cnt;
    int n_chk = 0, n_err = 0;
    int m_last = 3, m_done = 0, cyc = 0;

    add_const_arbiter #(.WIDTH(W), .ADDEND(ADD)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_data(req_data),
        .o_gnt(gnt), .o_busy(busy), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_out_id(out_id), .o_done_cnt(done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) if (r[(m_last + k) % 4]) return (m_last + k) % 4;
        return -1;
    endfunction

    function automatic logic [W-1:0] sum_of(input int op);
        return W'((op + ADD) % (1 << W));
    endfunction

    task automatic wait_gnt(output bit got);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (gnt !== 4'b0) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++; if (gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
            n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", out_valid); end
            n_chk++; if (out_data !== '0) begin n_err++; $display("FAIL reset_data got %0d exp 0", out_data); end
            n_chk++; if (out_id !== 2'd0) begin n_err++; $display("FAIL reset_id got %0d exp 0", out_id); end
            n_chk++; if (done_cnt !== 8'd0) begin n_err++; $display("FAIL reset_done got %0d exp 0", done_cnt); end
            n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        end
        req = 4'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        bit got;
        int exp;
        req_data = W'(0) | ($urandom & 16'hF0FF);
        req_data[2*W +: W] = 4'd5;
        req = 4'b0100;
        out_ready = 1'b1;
        exp = pick(req);
        wait_gnt(got);
        n_chk++; if (!got) begin n_err++; $display("FAIL single_gnt_timeout got none exp grant"); end
        n_chk++; if (gnt !== 4'(1 << exp)) begin n_err++; $display("FAIL single_gnt got %b exp %b", gnt, 4'(1 << exp)); end
        m_last = exp;
        req = 4'b0;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b exp 1", out_valid); end
        n_chk++; if (out_data !== 4'd8) begin n_err++; $display("FAIL single_data got %0d exp 8", out_data); end
        n_chk++; if (out_id !== 2'd2) begin n_err++; $display("FAIL single_id got %0d exp 2", out_id); end
        n_chk++; if (gnt !== 4'b0) begin n_err++; $display("FAIL single_gnt_drop got %b exp 0000", gnt); end
        m_done++;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop got %b exp 0", out_valid); end
        n_chk++; if (done_cnt !== 8'(m_done)) begin n_err++; $display("FAIL single_done got %0d exp %0d", done_cnt, m_done); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy got %b exp 0", busy); end
    endtask

    task automatic test_wrap;
        int ops[3] = '{13, 15, 0};
        bit got;
        int exp;
        out_ready = 1'b1;
        foreach (ops[i]) begin
            req_data[0 +: W] = W'(ops[i]);
            req = 4'b0001;
            exp = pick(req);
            wait_gnt(got);
            n_chk++; if (gnt !== 4'(1 << exp) || !got) begin n_err++; $display("FAIL wrap_gnt got %b exp %b", gnt, 4'(1 << exp)); end
            m_last = exp;
            req = 4'b0;
            @(negedge clk);
            n_chk++; if (out_data !== sum_of(ops[i])) begin n_err++; $display("FAIL wrap_data got %0d exp %0d", out_data, sum_of(ops[i])); end
            m_done++;
            @(negedge clk);
        end
        n_chk++; if (done_cnt !== 8'(m_done)) begin n_err++; $display("FAIL wrap_done got %0d exp %0d", done_cnt, m_done); end
    endtask

    task automatic test_round_robin;
        bit got;
        int exp, prev = -1;
        for (int i = 0; i < 4; i++) req_data[i*W +: W] = W'($urandom_range(0, 15));
        req = 4'hF;
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            exp = pick(req);
            wait_gnt(got);
            n_chk++; if (!got) begin n_err++; $display("FAIL rr_timeout got none exp grant %0d", exp); break; end
            n_chk++; if (gnt !== 4'(1 << exp)) begin n_err++; $display("FAIL rr_gnt got %b exp %b", gnt, 4'(1 << exp)); end
            if (prev >= 0) begin
                n_chk++; if (cyc - prev != 3) begin n_err++; $display("FAIL rr_period got %0d exp 3", cyc - prev); end
            end
            prev = cyc;
            m_last = exp;
            @(negedge clk);
            n_chk++; if (out_data !== sum_of(int'(req_data[exp*W +: W]))) begin n_err++; $display("FAIL rr_data got %0d exp %0d", out_data, sum_of(int'(req_data[exp*W +: W]))); end
            n_chk++; if (out_id !== 2'(exp)) begin n_err++; $display("FAIL rr_id got %0d exp %0d", out_id, exp); end
            m_done++;
        end
        req = 4'b0;
        @(negedge clk);
        n_chk++; if (done_cnt !== 8'(m_done)) begin n_err++; $display("FAIL rr_done got %0d exp %0d", done_cnt, m_done); end
    endtask

    task automatic test_backpressure;
        bit got;
        int exp;
        logic [W-1:0] op, held;
        op = W'($urandom_range(0, 15));
        req_data[3*W +: W] = op;
        out_ready = 1'b0;
        req = 4'b1000;
        exp = pick(req);
        wait_gnt(got);
        n_chk++; if (gnt !== 4'(1 << exp) || !got) begin n_err++; $display("FAIL bp_gnt got %b exp %b", gnt, 4'(1 << exp)); end
        m_last = exp;
        req = 4'b0001;
        @(negedge clk);
        held = sum_of(int'(op));
        n_chk++; if (out_valid !== 1'b1 || out_data !== held) begin n_err++; $display("FAIL bp_first got v=%b d=%0d exp v=1 d=%0d", out_valid, out_data, held); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++; if (out_valid !== 1'b1 || out_data !== held || out_id !== 2'(exp)) begin n_err++; $display("FAIL bp_hold got v=%b d=%0d id=%0d exp v=1 d=%0d id=%0d", out_valid, out_data, out_id, held, exp); end
            n_chk++; if (gnt !== 4'b0 || busy !== 1'b1) begin n_err++; $display("FAIL bp_idle got gnt=%b busy=%b exp gnt=0000 busy=1", gnt, busy); end
        end
        req = 4'b0;
        out_ready = 1'b1;
        m_done++;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0 || done_cnt !== 8'(m_done)) begin n_err++; $display("FAIL bp_release got v=%b done=%0d exp v=0 done=%0d", out_valid, done_cnt, m_done); end
    endtask

    task automatic test_reset_mid;
        bit got;
        req = 4'hF;
        out_ready = 1'b1;
        wait_gnt(got);
        rst_n = 1'b0;
        @(negedge clk);
        m_last = 3;
        m_done = 0;
        n_chk++; if (out_valid !== 1'b0 || gnt !== 4'b0 || done_cnt !== 8'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rstc got v=%b gnt=%b done=%0d busy=%b exp all 0", out_valid, gnt, done_cnt, busy); end
        rst_n = 1'b1;
        wait_gnt(got);
        n_chk++; if (gnt !== 4'(1 << pick(req)) || !got) begin n_err++; $display("FAIL rstc_first_gnt got %b exp 0001", gnt); end
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rsth_valid got %b exp 1", out_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0 || gnt !== 4'b0 || done_cnt !== 8'd0) begin n_err++; $display("FAIL rsth got v=%b gnt=%b done=%0d exp all 0", out_valid, gnt, done_cnt); end
        @(negedge clk);
        n_chk++; if (gnt !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rsth_hold got gnt=%b busy=%b exp 0", gnt, busy); end
        rst_n = 1'b1;
        wait_gnt(got);
        n_chk++; if (gnt !== 4'(1 << pick(req)) || !got) begin n_err++; $display("FAIL rsth_first_gnt got %b exp 0001", gnt); end
        m_last = 0;
        req = 4'b0;
        m_done++;
        repeat (2) @(negedge clk);
        n_chk++; if (done_cnt !== 8'(m_done)) begin n_err++; $display("FAIL rst_done got %0d exp %0d", done_cnt, m_done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
